// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer
//   Buffers bytes from the upstream counter in a small FIFO and serialises
//   each one as a UART frame (8N1, or 8E1 when UART_PARITY_EN is defined).
//
//   Optional feature macro: UART_PARITY_EN (adds an even-parity bit).
//
//   Parameters
//     CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//     FIFO_DEPTH   : byte buffer depth (power of two, >= 2)
//
//   Ports
//     i_Clk       : system clock, rising edge
//     i_Rst_n     : asynchronous active-low reset
//     i_Data_DV   : one-cycle strobe qualifying i_Data
//     i_Data      : byte to transmit
//     o_Tx_Active : FIFO non-empty or frame in progress (registered)
//     o_Full      : FIFO holds FIFO_DEPTH bytes (registered)
//     o_Overflow  : sticky, a byte was dropped
//     o_Tx_Serial : UART line, idle high
//     o_Tx_Done   : one-cycle pulse during the final stop-bit cycle
module uart_frame_streamer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Data_DV,
  input  logic [7:0] i_Data,
  output logic       o_Tx_Active,
  output logic       o_Full,
  output logic       o_Overflow,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] OCC_FULL  = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic          baud_last;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    shift_p0;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next, occ_next;
  logic          fifo_empty, push, pop;

  logic          tx_line_p0, tx_done_p0, tx_active_p0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  // o_Full always mirrors the current occupancy, so it can gate the push.
  assign push       = i_Data_DV & ~o_Full;
  assign wr_next    = wr_ptr + PW'(push);
  assign rd_next    = rd_ptr + PW'(pop);
  assign occ_next   = wr_next - rd_next;
  assign baud_last  = (baud == BAUD_LAST);

  always_comb begin
    state_next = state;
    baud_next  = baud_last ? '0 : baud + BW'(1);
    bit_next   = bit_idx;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (baud_last) state_next = S_DATA;
      end
      S_DATA: begin
        if (baud_last) begin
          bit_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_last) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          bit_next = '0;
          // Chain straight into the next frame to avoid an idle gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_line_p0 = 1'b1;
    case (state)
      S_START:  tx_line_p0 = 1'b0;
      S_DATA:   tx_line_p0 = shift_p0[bit_idx];
`ifdef UART_PARITY_EN
      S_PARITY: tx_line_p0 = ^shift_p0;
`endif
      default:  tx_line_p0 = 1'b1;
    endcase
  end

  assign tx_done_p0   = (state == S_STOP) && baud_last;
  assign tx_active_p0 = (state != S_IDLE) || !fifo_empty;

  // Data storage: FIFO array and shift register carry no reset.
  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_Data;
    if (pop)  shift_p0 <= mem[rd_ptr[AW-1:0]];
  end

  // Stage p0 -> p1: FSM/FIFO state and the registered line outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= S_IDLE;
      baud        <= '0;
      bit_idx     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_Full      <= 1'b0;
      o_Overflow  <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Done   <= 1'b0;
      o_Tx_Active <= 1'b0;
    end else begin
      state       <= state_next;
      baud        <= baud_next;
      bit_idx     <= bit_next;
      wr_ptr      <= wr_next;
      rd_ptr      <= rd_next;
      o_Full      <= (occ_next == OCC_FULL);
      if (i_Data_DV && o_Full) o_Overflow <= 1'b1;
      o_Tx_Serial <= tx_line_p0;
      o_Tx_Done   <= tx_done_p0;
      o_Tx_Active <= tx_active_p0;
    end
  end

endmodule

// File: tb/tb_uart_frame_streamer.sv
module tb_uart_frame_streamer;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx_active, full, overflow, tx_serial, tx_done;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_frame_streamer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Data_DV(dv), .i_Data(data),
    .o_Tx_Active(tx_active), .o_Full(full), .o_Overflow(overflow),
    .o_Tx_Serial(tx_serial), .o_Tx_Done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    dv   = 1'b1;
    data = b;
    @(negedge clk);
    dv   = 1'b0;
  endtask

  // Checks one frame cycle by cycle, starting at frame cycle 'skip' at the
  // current time; returns positioned in the last stop-bit cycle.
  task automatic frame_chk(input logic [7:0] b, input int skip, input string tag);
    int   nc;
    int   k;
    logic exp_line;
    nc = NBITS * CPB;
    for (int i = skip; i < nc; i++) begin
      if (i > skip) tick();
      k = i / CPB;
      if (k == 0)                exp_line = 1'b0;
      else if (k <= 8)           exp_line = b[k-1];
      else if (PAR && k == 9)    exp_line = ^b;
      else                       exp_line = 1'b1;
      chk({tag, "_line"}, 32'(tx_serial), 32'(exp_line));
      chk({tag, "_done"}, 32'(tx_done), 32'(i == nc - 1));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_serial",   32'(tx_serial), 32'd1);
    chk("rst_active",   32'(tx_active), 32'd0);
    chk("rst_full",     32'(full),      32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_done",     32'(tx_done),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single byte 0xA5: line low from DV edge + 2, done at +41
    send(8'hA5);
    chk("a5_lat0", 32'(tx_serial), 32'd1);
    tick();
    chk("a5_lat1", 32'(tx_serial), 32'd1);
    chk("a5_act",  32'(tx_active), 32'd1);
    tick();
    frame_chk(8'hA5, 0, "a5");
    tick();
    chk("a5_act_fall", 32'(tx_active), 32'd0);
    chk("a5_idle",     32'(tx_serial), 32'd1);
    chk("a5_done_lo",  32'(tx_done),   32'd0);
    repeat (3) tick();

    // Back-to-back 0x01, 0x02, 0x03: contiguous frames
    @(negedge clk); dv = 1'b1; data = 8'h01;
    @(negedge clk); data = 8'h02;
    @(negedge clk); data = 8'h03;
    @(posedge clk); #1;
    dv = 1'b0;
    frame_chk(8'h01, 0, "b2b1");
    tick();
    frame_chk(8'h02, 0, "b2b2");
    tick();
    frame_chk(8'h03, 0, "b2b3");
    tick();
    chk("b2b_idle", 32'(tx_serial), 32'd1);
    chk("b2b_act",  32'(tx_active), 32'd0);
    chk("b2b_done", 32'(tx_done),   32'd0);
    repeat (3) tick();

    // Overflow: six strobes 0x10..0x15, 0x15 dropped
    @(negedge clk); dv = 1'b1; data = 8'h10;
    @(negedge clk); data = 8'h11;
    @(negedge clk); data = 8'h12;
    @(negedge clk); data = 8'h13;
    @(negedge clk); data = 8'h14;
    @(negedge clk);
    chk("ovf_full",   32'(full),     32'd1);
    chk("ovf_pre",    32'(overflow), 32'd0);
    data = 8'h15;
    @(negedge clk);
    dv = 1'b0;
    chk("ovf_set",    32'(overflow), 32'd1);
    chk("ovf_full2",  32'(full),     32'd1);
    frame_chk(8'h10, 3, "ovf10");
    tick(); frame_chk(8'h11, 0, "ovf11");
    tick(); frame_chk(8'h12, 0, "ovf12");
    tick(); frame_chk(8'h13, 0, "ovf13");
    tick(); frame_chk(8'h14, 0, "ovf14");
    tick();
    chk("ovf_idle",   32'(tx_serial), 32'd1);
    chk("ovf_act",    32'(tx_active), 32'd0);
    chk("ovf_full0",  32'(full),      32'd0);
    chk("ovf_sticky", 32'(overflow),  32'd1);
    repeat (3) tick();

    // Parity patterns (odd and even number of ones)
    send(8'h07);
    tick(); tick();
    frame_chk(8'h07, 0, "p07");
    repeat (3) tick();
    send(8'h03);
    tick(); tick();
    frame_chk(8'h03, 0, "p03");
    repeat (3) tick();

    // Reset during DATA bit 3 of 0x55 with 0x66, 0x77 queued
    @(negedge clk); dv = 1'b1; data = 8'h55;
    @(negedge clk); data = 8'h66;
    @(negedge clk); data = 8'h77;
    @(negedge clk); dv = 1'b0;
    repeat (17) tick();
    chk("mr_bit3", 32'(tx_serial), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_serial",   32'(tx_serial), 32'd1);
    chk("mr_active",   32'(tx_active), 32'd0);
    chk("mr_full",     32'(full),      32'd0);
    chk("mr_overflow", 32'(overflow),  32'd0);
    chk("mr_done",     32'(tx_done),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("mr_quiet_line", 32'(tx_serial), 32'd1);
      chk("mr_quiet_done", 32'(tx_done),   32'd0);
    end
    chk("mr_quiet_act", 32'(tx_active), 32'd0);

    // Recovery after reset
    send(8'h3C);
    tick(); tick();
    frame_chk(8'h3C, 0, "rec");
    tick();
    chk("rec_act", 32'(tx_active), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_streamer.md
# uart_frame_streamer

Downstream stage of the 8-bit counter: accepts count bytes on a valid strobe, buffers them in a small FIFO and serialises each one as an 8N1 UART frame on a single TX line. It drives the busy indication the counter uses to hold off new bytes. One clock domain at 50 MHz, 115200 baud by default.

## Interface

- CLKS_PER_BIT, default 434: clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, default 4: byte buffer depth; must be a power of two, ≥ 2.

- i_Clk  input  1  system clock; all state on the rising edge.
- i_Rst_n  input  1  reset, asynchronous, active-low.
- i_Data_DV  input  1  one-cycle strobe; i_Data is valid this cycle.
- i_Data  input  8  byte to transmit.
- o_Tx_Active  output  1  high while the FIFO is non-empty or a frame is in progress.
- o_Full  output  1  FIFO holds FIFO_DEPTH bytes.
- o_Overflow  output  1  sticky; a byte was dropped.
- o_Tx_Serial  output  1  UART line, idle high.
- o_Tx_Done  output  1  one-cycle pulse at the end of each stop bit.

## Operation

- Write: on i_Data_DV with o_Full low, the byte is pushed. With o_Full high, the byte is dropped and o_Overflow is set, even if a pop occurs in the same cycle. o_Overflow stays set until reset.
- FSM states are IDLE, START, DATA, PARITY (only when PARITY_EN is defined) and STOP.
  - IDLE: line high. If the FIFO is non-empty, pop the head into the shift register, clear the bit and baud counters, and go to START.
  - START: line low for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB-first, each held CLKS_PER_BIT cycles. After bit 7, go to PARITY or STOP.
  - PARITY: even parity of the byte for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: line high for CLKS_PER_BIT cycles. On the last cycle, pulse o_Tx_Done. If the FIFO is non-empty, pop and go straight to START, so there is no idle gap. Otherwise go to IDLE.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. Simultaneous push and pop with the FIFO not full leaves the occupancy unchanged.
- o_Tx_Active = (FSM != IDLE) | FIFO non-empty.

## Timing

- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Full=0, o_Overflow=0, o_Tx_Done=0. FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-frame: the line returns high immediately (asynchronously), the frame is abandoned and the FIFO is flushed. No o_Tx_Done is produced for that frame.
- Latency: with the FIFO empty and the FSM in IDLE, a DV sampled at edge N gives o_Tx_Serial low from edge N+2.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with PARITY_EN.
- o_Tx_Done is high during the final stop-bit cycle only.
- o_Full and o_Tx_Active are registered and update the cycle after the push or pop that changes them.

## Configuration

- UART_PARITY_EN defined: the PARITY state is compiled in and each frame carries an even-parity bit between bit 7 and stop (8E1).
- UART_PARITY_EN not defined: no parity state or logic, and frames are 8N1.

## Test plan

- **Single byte.** CLKS_PER_BIT=4, send 0xA5 into an idle block.
  - Line low from edge+2.
  - Line sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - o_Tx_Done pulses 41 cycles after the DV edge.
  - o_Tx_Active falls the cycle after.
- **Back-to-back bytes.** Send 0x01,0x02,0x03 on consecutive cycles.
  - Three contiguous 40-cycle frames with no idle high gap between them.
  - Exactly three o_Tx_Done pulses.
- **Overflow.** FIFO_DEPTH=4, six consecutive DV strobes carrying 0x10–0x15.
  - 0x10 is popped immediately; 0x11–0x14 are buffered; o_Full goes high.
  - 0x15 is dropped and o_Overflow goes to 1 and stays there.
  - Output is five frames, 0x10–0x14.
- **Parity.** UART_PARITY_EN defined, send 0x07.
  - Parity bit is 1; frame is 44 cycles at CLKS_PER_BIT=4.
  - Send 0x03: parity bit is 0.
- **Reset mid-frame.** Assert i_Rst_n low during DATA bit 3 with two bytes queued.
  - Line goes high without waiting for a clock edge; all flags clear.
  - After release there is no transmission until a new DV.
